icnbc_nearest_decoder: RTL and testbench

//  Downstream consumer of the ICNBC code search stage. Loads the codebook the search emits, one codeword per beat.

---
 rtl/icnbc_pkg.sv | 13 +
 rtl/icnbc_code_ram.sv | 20 ++
 rtl/icnbc_nearest_decoder.sv | 121 ++++++++++++
 tb/tb_icnbc_nearest_decoder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/icnbc_pkg.sv
// icnbc_pkg: shared ICNBC constants, decoder state encoding and popcount helper
package icnbc_pkg;
  localparam int ICNBC_N      = 8;
  localparam int ICNBC_DEPTH  = 16;
  localparam int ICNBC_ADDR_W = $clog2(ICNBC_DEPTH);
  localparam int ICNBC_D_W    = $clog2(ICNBC_N + 1);
  typedef enum logic [1:0] {LOAD, READY, SCAN, OUT} state_t;
  // Counts set bits of a word of up to 32 bits; callers zero-extend narrower words.
  function automatic logic [5:0] popcount(input logic [31:0] v);
    popcount = '0;
    for (int i = 0; i < 32; i++) popcount = popcount + 6'(v[i]);
  endfunction
endpackage

// File: rtl/icnbc_code_ram.sv
// icnbc_code_ram: 1W/1R synchronous codebook RAM, DEPTH x N, contents not reset
module icnbc_code_ram #(
  parameter int N      = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [N-1:0]      i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [N-1:0]      o_rdata
);
  logic [N-1:0] r_mem [DEPTH];
  // Write port and registered read port; same-address read/write ordering is don't-care.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/icnbc_nearest_decoder.sv
// icnbc_nearest_decoder: loads a codebook then maps received words to the nearest codeword by Hamming distance
// Optional feature macro ICNBC_DEC_ERRFLAG_EN drives dec_uncorr from min_ld; otherwise dec_uncorr is 0.
module icnbc_nearest_decoder
  import icnbc_pkg::*;
#(
  parameter int N      = ICNBC_N,
  parameter int DEPTH  = ICNBC_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int D_W    = $clog2(N + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              cw_valid,
  output logic              cw_ready,
  input  logic [N-1:0]      cw_data,
  input  logic              cw_last,
  output logic [ADDR_W:0]   book_size,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [N-1:0]      rx_word,
  input  logic [D_W-1:0]    min_ld,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [ADDR_W-1:0] dec_index,
  output logic [D_W-1:0]    dec_dist,
  output logic              dec_uncorr
);
  state_t            r_state;
  logic [N-1:0]      r_rx;
  logic [ADDR_W:0]   r_addr;
  logic              r_cmp_v;
  logic [ADDR_W-1:0] r_cmp_idx;
  logic [D_W-1:0]    r_best_dist;
  logic [ADDR_W-1:0] r_best_idx;
  logic [N-1:0]      w_q;
  logic [D_W-1:0]    w_dist;
  logic              w_cw_acc;
  logic              w_rx_acc;
  logic              w_uncorr;

  assign cw_ready = r_state == LOAD && book_size < (ADDR_W+1)'(DEPTH);
  assign rx_ready = r_state == READY && book_size != '0;
  assign w_cw_acc = cw_valid && cw_ready;
  assign w_rx_acc = rx_valid && rx_ready;
  assign w_dist   = D_W'(popcount(32'(w_q ^ r_rx)));
`ifdef ICNBC_DEC_ERRFLAG_EN
  assign w_uncorr = {r_best_dist, 1'b0} >= {1'b0, min_ld};
`else
  logic w_unused_min_ld;
  assign w_unused_min_ld = ^min_ld;
  assign w_uncorr = 1'b0;
`endif

  icnbc_code_ram #(.N(N), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .i_we    (w_cw_acc),
    .i_waddr (book_size[ADDR_W-1:0]),
    .i_wdata (cw_data),
    .i_raddr (r_addr[ADDR_W-1:0]),
    .o_rdata (w_q)
  );

  // Control FSM: load book, accept a word, scan one entry per clock with a one-cycle RAM lag, hold result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= LOAD;
      book_size   <= '0;
      dec_valid   <= 1'b0;
      dec_index   <= '0;
      dec_dist    <= '0;
      dec_uncorr  <= 1'b0;
      r_rx        <= '0;
      r_addr      <= '0;
      r_cmp_v     <= 1'b0;
      r_cmp_idx   <= '0;
      r_best_dist <= '0;
      r_best_idx  <= '0;
    end else if (flush) begin
      r_state   <= LOAD;
      book_size <= '0;
      dec_valid <= 1'b0;
    end else begin
      case (r_state)
        LOAD: if (w_cw_acc) begin
          book_size <= book_size + 1'b1;
          if (cw_last || book_size == (ADDR_W+1)'(DEPTH - 1)) r_state <= READY;
        end
        READY: if (w_rx_acc) begin
          r_rx        <= rx_word;
          r_addr      <= '0;
          r_cmp_v     <= 1'b0;
          r_best_dist <= D_W'(N);
          r_best_idx  <= '0;
          r_state     <= SCAN;
        end
        SCAN: begin
          r_cmp_v   <= r_addr < book_size;
          r_cmp_idx <= r_addr[ADDR_W-1:0];
          if (r_addr < book_size) r_addr <= r_addr + 1'b1;
          if (r_cmp_v && w_dist < r_best_dist) begin
            r_best_dist <= w_dist;
            r_best_idx  <= r_cmp_idx;
          end
          if (!r_cmp_v && r_addr == book_size) begin
            dec_valid  <= 1'b1;
            dec_index  <= r_best_idx;
            dec_dist   <= r_best_dist;
            dec_uncorr <= w_uncorr;
            r_state    <= OUT;
          end
        end
        OUT: if (dec_ready) begin
          dec_valid <= 1'b0;
          r_state   <= READY;
        end
        default: r_state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_icnbc_nearest_decoder.sv
// tb_icnbc_nearest_decoder: directed self-checking bench for the nearest-codeword decoder
module tb_icnbc_nearest_decoder;
`ifdef ICNBC_DEC_ERRFLAG_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  logic       clk = 0;
  logic       rst = 1;
  logic       flush = 0;
  logic       cw_valid = 0;
  logic       cw_ready;
  logic [7:0] cw_data = 0;
  logic       cw_last = 0;
  logic [4:0] book_size;
  logic       rx_valid = 0;
  logic       rx_ready;
  logic [7:0] rx_word = 0;
  logic [3:0] min_ld = 4'd4;
  logic       dec_valid;
  logic       dec_ready = 0;
  logic [3:0] dec_index;
  logic [3:0] dec_dist;
  logic       dec_uncorr;
  int vectors = 0;
  int miscompares = 0;

  icnbc_nearest_decoder dut (
    .clk(clk), .rst(rst), .flush(flush),
    .cw_valid(cw_valid), .cw_ready(cw_ready), .cw_data(cw_data), .cw_last(cw_last),
    .book_size(book_size),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_word(rx_word), .min_ld(min_ld),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_index(dec_index),
    .dec_dist(dec_dist), .dec_uncorr(dec_uncorr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic load_beat(input logic [7:0] d, input logic last);
    cw_valid = 1;
    cw_data  = d;
    cw_last  = last;
    tick();
    cw_valid = 0;
    cw_last  = 0;
  endtask

  task automatic load_basic();
    load_beat(8'h00, 0);
    load_beat(8'h0F, 0);
    load_beat(8'hF0, 0);
    load_beat(8'hFF, 1);
  endtask

  task automatic run_decode(input logic [7:0] rx, input int exp_idx, input int exp_dist,
                            input int exp_lat, input string name);
    int lat = 0;
    logic exp_unc;
    exp_unc = ERR && (2 * exp_dist >= 4);
    rx_valid = 1;
    rx_word  = rx;
    while (!rx_ready && lat < 20) begin tick(); lat++; end
    vectors++;
    if (rx_ready !== 1'b1) begin miscompares++; $display("FAIL %s rx_ready wait: got %b expected 1", name, rx_ready); end
    tick();
    rx_valid = 0;
    lat = 0;
    while (!dec_valid && lat < 40) begin tick(); lat++; end
    vectors++;
    if (lat !== exp_lat) begin miscompares++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat); end
    vectors++;
    if (dec_index !== 4'(exp_idx)) begin miscompares++; $display("FAIL %s dec_index: got %0d expected %0d", name, dec_index, exp_idx); end
    vectors++;
    if (dec_dist !== 4'(exp_dist)) begin miscompares++; $display("FAIL %s dec_dist: got %0d expected %0d", name, dec_dist, exp_dist); end
    vectors++;
    if (dec_uncorr !== exp_unc) begin miscompares++; $display("FAIL %s dec_uncorr: got %b expected %b", name, dec_uncorr, exp_unc); end
    dec_ready = 1;
    tick();
    dec_ready = 0;
    vectors++;
    if (dec_valid !== 1'b0 || rx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s post-handshake valid/rx_ready: got %b/%b expected 0/1", name, dec_valid, rx_ready);
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({dec_valid, dec_index, dec_dist, dec_uncorr, book_size} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset outputs: got v%b i%0d d%0d u%b bs%0d expected all 0", dec_valid, dec_index, dec_dist, dec_uncorr, book_size);
    end
    vectors++;
    if (cw_ready !== 1'b1 || rx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset ready: got cw%b rx%b expected cw1 rx0", cw_ready, rx_ready);
    end
  endtask

  task automatic test_basic_decode();
    load_basic();
    vectors++;
    if (book_size !== 5'd4 || cw_ready !== 1'b0 || rx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL load4 state: got bs%0d cw%b rx%b expected bs4 cw0 rx1", book_size, cw_ready, rx_ready);
    end
    run_decode(8'h0E, 1, 1, 6, "rx0E");
    run_decode(8'h03, 0, 2, 6, "rx03_tie");
    run_decode(8'hF8, 2, 1, 6, "rxF8");
    run_decode(8'hFF, 3, 0, 6, "rxFF_last");
  endtask

  task automatic test_backpressure();
    int lat = 0;
    logic bad = 0;
    rx_valid = 1;
    rx_word  = 8'h0E;
    tick();
    rx_valid = 0;
    while (!dec_valid && lat < 40) begin tick(); lat++; end
    for (int k = 0; k < 5; k++) begin
      if (dec_valid !== 1'b1 || dec_index !== 4'd1 || dec_dist !== 4'd1 || rx_ready !== 1'b0) bad = 1;
      tick();
    end
    vectors++;
    if (bad) begin miscompares++; $display("FAIL hold: got v%b i%0d d%0d rx%b expected v1 i1 d1 rx0", dec_valid, dec_index, dec_dist, rx_ready); end
    dec_ready = 1;
    rx_valid  = 1;
    rx_word   = 8'hF0;
    tick();
    dec_ready = 0;
    vectors++;
    if (dec_valid !== 1'b0 || rx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b after handshake: got v%b rx%b expected v0 rx1", dec_valid, rx_ready);
    end
    tick();
    rx_valid = 0;
    vectors++;
    if (rx_ready !== 1'b0) begin miscompares++; $display("FAIL b2b accept: got rx_ready %b expected 0", rx_ready); end
    lat = 0;
    while (!dec_valid && lat < 40) begin tick(); lat++; end
    vectors++;
    if (lat !== 6 || dec_index !== 4'd2 || dec_dist !== 4'd0) begin
      miscompares++;
      $display("FAIL b2b result: got lat%0d i%0d d%0d expected lat6 i2 d0", lat, dec_index, dec_dist);
    end
    dec_ready = 1;
    tick();
    dec_ready = 0;
  endtask

  task automatic test_abort(input bit use_rst);
    logic rose = 0;
    rx_valid = 1;
    rx_word  = 8'h0E;
    tick();
    rx_valid = 0;
    tick();
    tick();
    if (use_rst) rst = 1; else flush = 1;
    tick();
    rst = 0;
    flush = 0;
    vectors++;
    if (book_size !== 5'd0 || cw_ready !== 1'b1 || rx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL abort%0d state: got bs%0d cw%b rx%b expected bs0 cw1 rx0", use_rst, book_size, cw_ready, rx_ready);
    end
    for (int k = 0; k < 12; k++) begin
      if (dec_valid) rose = 1;
      tick();
    end
    vectors++;
    if (rose) begin miscompares++; $display("FAIL abort%0d dec_valid: got 1 expected 0", use_rst); end
  endtask

  task automatic test_full_book();
    for (int k = 0; k < 16; k++) load_beat(8'(k * 17), 0);
    vectors++;
    if (book_size !== 5'd16 || cw_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL full book: got bs%0d cw%b expected bs16 cw0", book_size, cw_ready);
    end
    load_beat(8'hAA, 1);
    vectors++;
    if (book_size !== 5'd16) begin miscompares++; $display("FAIL 17th beat: got bs%0d expected 16", book_size); end
    run_decode(8'h23, 2, 1, 18, "full_tie");
    run_decode(8'hFF, 15, 0, 18, "full_last");
  endtask

  task automatic test_single_entry();
    flush = 1;
    tick();
    flush = 0;
    load_beat(8'h5A, 1);
    vectors++;
    if (book_size !== 5'd1 || rx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL single load: got bs%0d rx%b expected bs1 rx1", book_size, rx_ready);
    end
    run_decode(8'hA5, 0, 8, 3, "single_maxdist");
  endtask

  initial begin
    test_reset();
    test_basic_decode();
    test_backpressure();
    test_abort(0);
    load_basic();
    test_abort(1);
    test_full_book();
    test_single_entry();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
